// File: rtl/perf_pkg.sv
// Shared FSM type, default parameters and counter slot indices for perf_monitor.
package perf_pkg;

  localparam int          PERF_CNT_W      = 32;
  localparam logic [31:0] PERF_HALT_INST  = 32'hFFFF_FFFF;
  localparam int          PERF_WDOG_LIMIT = 1024;

  // Slot order inside the counter bank; stall slots exist only when stall counting is built.
  localparam int CNT_INST   = 0;
  localparam int CNT_CYCLE  = 1;
  localparam int CNT_HAZARD = 2;
  localparam int CNT_CACHE  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } perf_state_e;

  // Watchdog counter must be able to hold WDOG_LIMIT-1.
  function automatic int wdog_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/perf_monitor_if.sv
// Writeback/stall observation inputs and counter outputs of perf_monitor.
interface perf_monitor_if
  import perf_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W
);

  logic             retire_valid;
  logic [31:0]      retire_inst;
  logic             hazard_stall;
  logic             cache_stall;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] hazard_stall_count;
  logic [CNT_W-1:0] cache_stall_count;
  logic             stop;
  logic             timeout;

  modport master (
    output retire_valid, retire_inst, hazard_stall, cache_stall,
    input  inst_count, cycle_count, hazard_stall_count, cache_stall_count, stop, timeout
  );

  modport slave (
    input  retire_valid, retire_inst, hazard_stall, cache_stall,
    output inst_count, cycle_count, hazard_stall_count, cache_stall_count, stop, timeout
  );

endinterface

// File: rtl/perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and freeze; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             freeze,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !freeze && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Retirement-side performance monitor: instruction/cycle/stall counters plus halt detection.
// Optional feature macro: PERF_STALL_CNT_EN builds the hazard/cache stall counters.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int          CNT_W      = PERF_CNT_W,
  parameter logic [31:0] HALT_INST  = PERF_HALT_INST,
  parameter int          WDOG_LIMIT = PERF_WDOG_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  perf_monitor_if.slave mon
);

  localparam int              WD_W    = wdog_width(WDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);
`ifdef PERF_STALL_CNT_EN
  localparam int NUM_CNT = 4;
`else
  localparam int NUM_CNT = 2;
`endif

  perf_state_e     state_reg, state_next;
  logic [WD_W-1:0] wdog_reg, wdog_next;
  logic            stop_reg, stop_next;
  logic            timeout_reg, timeout_next;

  logic             inst_inc;
  logic             cycle_inc;
  logic             stall_cycle;
  logic             is_halt_word;
  logic             frozen;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0]   cnt_val [NUM_CNT];

  assign is_halt_word = mon.retire_valid && (mon.retire_inst == HALT_INST);
  assign frozen       = (state_reg == HALT);

  always_comb begin
    state_next   = state_reg;
    wdog_next    = wdog_reg;
    stop_next    = stop_reg;
    timeout_next = timeout_reg;
    inst_inc     = 1'b0;
    cycle_inc    = 1'b0;
    stall_cycle  = 1'b0;
    if (clr) begin
      state_next   = IDLE;
      wdog_next    = '0;
      stop_next    = 1'b0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The first retire is itself cycle 1 of the program.
          if (mon.retire_valid) begin
            cycle_inc = 1'b1;
            wdog_next = '0;
            if (is_halt_word) begin
              state_next = HALT;
              stop_next  = 1'b1;
            end else begin
              inst_inc   = 1'b1;
              state_next = RUN;
            end
          end
        end
        RUN: begin
          cycle_inc = 1'b1;
          if (mon.retire_valid) begin
            wdog_next = '0;
            if (is_halt_word) begin
              state_next = HALT;
              stop_next  = 1'b1;
            end else begin
              inst_inc = 1'b1;
            end
          end else begin
            stall_cycle = 1'b1;
            // Halt on the edge where the quiet-cycle count would reach the limit.
            if (wdog_reg == WD_LAST) begin
              state_next   = HALT;
              stop_next    = 1'b1;
              timeout_next = 1'b1;
            end else begin
              wdog_next = wdog_reg + 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      wdog_reg    <= '0;
      stop_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wdog_reg    <= wdog_next;
      stop_reg    <= stop_next;
      timeout_reg <= timeout_next;
    end
  end

  assign cnt_inc[CNT_INST]  = inst_inc;
  assign cnt_inc[CNT_CYCLE] = cycle_inc;

`ifdef PERF_STALL_CNT_EN
  // A cycle stalled on both causes is charged to the cache only.
  assign cnt_inc[CNT_CACHE]  = stall_cycle & mon.cache_stall;
  assign cnt_inc[CNT_HAZARD] = stall_cycle & mon.hazard_stall & ~mon.cache_stall;
`else
  logic unused_stall_inputs;
  assign unused_stall_inputs = ^{mon.hazard_stall, mon.cache_stall, stall_cycle};
`endif

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH(CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (cnt_inc[gi]),
        .freeze(frozen),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign mon.inst_count  = cnt_val[CNT_INST];
  assign mon.cycle_count = cnt_val[CNT_CYCLE];
`ifdef PERF_STALL_CNT_EN
  assign mon.hazard_stall_count = cnt_val[CNT_HAZARD];
  assign mon.cache_stall_count  = cnt_val[CNT_CACHE];
`else
  assign mon.hazard_stall_count = '0;
  assign mon.cache_stall_count  = '0;
`endif
  assign mon.stop    = stop_reg;
  assign mon.timeout = timeout_reg;

endmodule
